// File: rtl/tff_sync_counter.sv
// rtl/tff_sync_counter.sv - modulo-(MAX+1) up/down counter exporting per-bit T-flop toggle enables
// Terminal count gates a registered wrap pulse; load clips to MAX and never counts as a wrap.
module tff_sync_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] t,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             at_max, at_zero, tc_raw;

   always_comb begin
      at_max  = (q_q == MAX_V);
      at_zero = (q_q == '0);
      tc_raw  = en & ~load & (up ? at_max : at_zero);

      q_d = q_q;
      if (load) begin
         q_d = (d > MAX_V) ? MAX_V : d;
      end else if (en) begin
         if (up) begin
            q_d = at_max ? '0 : q_q + ONE_V;
         end else begin
            q_d = at_zero ? MAX_V : q_q - ONE_V;
         end
      end

      // Outputs are forced quiet while reset is held so downstream T cells stay cleared.
      tc     = tc_raw & ~rst;
      t      = rst ? '0 : (q_q ^ q_d);
      wrap_d = tc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign qb   = ~q_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_sync_counter.sv
// tb/tb_tff_sync_counter.sv - directed and randomized bench for tff_sync_counter (WIDTH=4, MAX=9)
module tb_tff_sync_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load;
   logic [3:0] d, q, qb, t;
   logic       tc, wrap;
   logic [3:0] sh;
   int         total = 0;
   int         bad = 0;

   tff_sync_counter #(.WIDTH(4), .MAX(9)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .q(q), .qb(qb), .t(t), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Reference bank of discrete T flip-flops driven only by t.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh <= '0;
      else     sh <= sh ^ t;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] model_next(input logic [3:0] cq, input logic e, input logic u,
                                             input logic l, input logic [3:0] dv);
      if (l)          return (dv > 4'd9) ? 4'd9 : dv;
      else if (e & u) return (cq == 4'd9) ? 4'd0 : cq + 4'd1;
      else if (e)     return (cq == 4'd0) ? 4'd9 : cq - 4'd1;
      else            return cq;
   endfunction

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; d = 4'd0;
      step();
      total++; if (q !== 4'd0)   begin bad++; $display("FAIL reset_q got=%h want=0", q); end
      total++; if (qb !== 4'hF)  begin bad++; $display("FAIL reset_qb got=%h want=f", qb); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
      total++; if (tc !== 1'b0)  begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
      total++; if (t !== 4'd0)   begin bad++; $display("FAIL reset_t got=%h want=0", t); end
      rst = 1'b0; en = 1'b0; load = 1'b1; d = 4'd7;
      step();
      total++; if (q !== 4'd7) begin bad++; $display("FAIL load7_q got=%h want=7", q); end
      load = 1'b0; en = 1'b1; up = 1'b1;
      #2 rst = 1'b1;
      #1;
      total++; if (q !== 4'd0)   begin bad++; $display("FAIL async_rst_q got=%h want=0", q); end
      total++; if (qb !== 4'hF)  begin bad++; $display("FAIL async_rst_qb got=%h want=f", qb); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL async_rst_wrap got=%b want=0", wrap); end
      step();
      total++; if (q !== 4'd0) begin bad++; $display("FAIL rst_held_q got=%h want=0", q); end
      rst = 1'b0;
      step();
      total++; if (q !== 4'd1) begin bad++; $display("FAIL post_rst_q got=%h want=1", q); end
      // Reset asserted during a terminal-count cycle must suppress the wrap pulse.
      load = 1'b1; d = 4'd9; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1; up = 1'b1;
      #1;
      total++; if (tc !== 1'b1) begin bad++; $display("FAIL pre_rst_tc got=%b want=1", tc); end
      rst = 1'b1;
      #1;
      total++; if (tc !== 1'b0) begin bad++; $display("FAIL rst_tc got=%b want=0", tc); end
      step();
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rst_tc_wrap got=%b want=0", wrap); end
      total++; if (q !== 4'd0)    begin bad++; $display("FAIL rst_tc_q got=%h want=0", q); end
      rst = 1'b0; en = 1'b0;
      step();
   endtask

   task automatic test_decade_up;
      logic [3:0] eq [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      logic [3:0] et [13] = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF, 4'h1, 4'h9, 4'h1, 4'h3, 4'h1};
      load = 1'b1; d = 4'd0; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 13; i++) begin
         #1;
         total++; if (q !== eq[i]) begin bad++; $display("FAIL up_q[%0d] got=%h want=%h", i, q, eq[i]); end
         total++; if (t !== et[i]) begin bad++; $display("FAIL up_t[%0d] got=%h want=%h", i, t, et[i]); end
         total++; if (tc !== (i == 9)) begin bad++; $display("FAIL up_tc[%0d] got=%b want=%b", i, tc, i == 9); end
         total++; if (wrap !== (i == 10)) begin bad++; $display("FAIL up_wrap[%0d] got=%b want=%b", i, wrap, i == 10); end
         step();
      end
   endtask

   task automatic test_decade_down;
      en = 1'b0; load = 1'b1; d = 4'd0;
      step();
      load = 1'b0; en = 1'b1; up = 1'b0;
      #1;
      total++; if (tc !== 1'b1) begin bad++; $display("FAIL dn_tc0 got=%b want=1", tc); end
      total++; if (t !== 4'h9)  begin bad++; $display("FAIL dn_t0 got=%h want=9", t); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_wrap_after_load got=%b want=0", wrap); end
      step();
      total++; if (q !== 4'd9)    begin bad++; $display("FAIL dn_q9 got=%h want=9", q); end
      total++; if (wrap !== 1'b1) begin bad++; $display("FAIL dn_wrap got=%b want=1", wrap); end
      total++; if (tc !== 1'b0)   begin bad++; $display("FAIL dn_tc9 got=%b want=0", tc); end
      total++; if (t !== 4'h1)    begin bad++; $display("FAIL dn_t9 got=%h want=1", t); end
      step();
      total++; if (q !== 4'd8)    begin bad++; $display("FAIL dn_q8 got=%h want=8", q); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_wrap8 got=%b want=0", wrap); end
      total++; if (t !== 4'hF)    begin bad++; $display("FAIL dn_t8 got=%h want=f", t); end
      step();
      total++; if (q !== 4'd7) begin bad++; $display("FAIL dn_q7 got=%h want=7", q); end
   endtask

   task automatic test_load_clip;
      en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd13;
      #1;
      total++; if (tc !== 1'b0) begin bad++; $display("FAIL clip_tc got=%b want=0", tc); end
      total++; if (t !== 4'hE)  begin bad++; $display("FAIL clip_t got=%h want=e", t); end
      step();
      total++; if (q !== 4'd9)    begin bad++; $display("FAIL clip_q got=%h want=9", q); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL clip_wrap got=%b want=0", wrap); end
      d = 4'd0;
      #1;
      total++; if (tc !== 1'b0) begin bad++; $display("FAIL load_at_max_tc got=%b want=0", tc); end
      step();
      total++; if (q !== 4'd0)    begin bad++; $display("FAIL load0_q got=%h want=0", q); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load0_wrap got=%b want=0", wrap); end
   endtask

   task automatic test_hold_dir;
      logic [3:0] eq [4] = '{4'd6, 4'd5, 4'd6, 4'd5};
      load = 1'b1; d = 4'd5; en = 1'b0;
      step();
      load = 1'b0;
      #1;
      total++; if (t !== 4'd0)  begin bad++; $display("FAIL hold_t got=%h want=0", t); end
      total++; if (tc !== 1'b0) begin bad++; $display("FAIL hold_tc got=%b want=0", tc); end
      step();
      total++; if (q !== 4'd5) begin bad++; $display("FAIL hold_q got=%h want=5", q); end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up = (i % 2 == 0);
         step();
         total++; if (q !== eq[i]) begin bad++; $display("FAIL flip_q[%0d] got=%h want=%h", i, q, eq[i]); end
      end
   endtask

   task automatic test_shadow;
      logic [3:0] exp_q;
      logic       exp_tc, prev_tc;
      exp_q = q;
      prev_tc = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         en   = $urandom_range(0, 3) != 0;
         up   = $urandom_range(0, 1) != 0;
         load = $urandom_range(0, 9) == 0;
         d    = 4'($urandom_range(0, 15));
         exp_tc = en & ~load & (up ? (exp_q == 4'd9) : (exp_q == 4'd0));
         #1;
         total++; if (tc !== exp_tc) begin bad++; $display("FAIL shadow_tc[%0d] got=%b want=%b", i, tc, exp_tc); end
         exp_q = model_next(exp_q, en, up, load, d);
         prev_tc = exp_tc;
         step();
         total++; if (q !== exp_q) begin bad++; $display("FAIL shadow_q[%0d] got=%h want=%h", i, q, exp_q); end
         total++; if (sh !== q)    begin bad++; $display("FAIL shadow_tff[%0d] got=%h want=%h", i, sh, q); end
         total++; if (wrap !== prev_tc) begin bad++; $display("FAIL shadow_wrap[%0d] got=%b want=%b", i, wrap, prev_tc); end
      end
   endtask

   initial begin
      test_reset();
      test_decade_up();
      test_decade_down();
      test_load_clip();
      test_hold_dir();
      test_shadow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tff_sync_counter.md
# tff_sync_counter

Synchronous modulo-N up/down counter whose bit slices follow toggle-flip-flop semantics: each state bit flips exactly when its toggle enable is high. It also exports the per-bit toggle-enable vector, so the block can directly drive a row of discrete single-bit T flip-flop cells elsewhere in the sequential library. It sits immediately upstream of those cells and provides the T-input generation plus the terminal-count and wrap logic that a bare T stage lacks.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16
- MAX, 2**WIDTH-1, highest count value before wrap; must satisfy 1 <= MAX <= 2**WIDTH-1
- clk  input  1  rising-edge clock, the block's only clock
- rst  input  1  asynchronous active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 counts up, 0 counts down
- load  input  1  synchronous parallel load
- d  input  WIDTH  load value
- q  output  WIDTH  registered count
- qb  output  WIDTH  bitwise complement of q (~q), combinational
- t  output  WIDTH  per-bit toggle enables, combinational, defined as q ^ q_next
- tc  output  1  terminal count, combinational
- wrap  output  1  registered one-cycle pulse following a wrap

## Operation
- The block has one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: q=0, wrap=0. Consequently qb is all ones, t=0 while rst is held, and tc=0 while rst is held.
- Next-state priority, evaluated at each rising clk edge:
  1. load=1: q_next = d when d <= MAX; otherwise q_next = MAX (saturating clip). en and up are ignored.
  2. en=1 and up=1: if q == MAX, q_next = 0; otherwise q_next = q + 1.
  3. en=1 and up=0: if q == 0, q_next = MAX; otherwise q_next = q - 1.
  4. Otherwise: q_next = q (hold; t = 0).
- t = q ^ q_next. A bank of T flip-flops that is reset together with this block and clocked with t must track q bit-for-bit.
- tc = en & ~load & (up ? (q == MAX) : (q == 0)). It is high only in the cycle in which the next edge wraps the count.
- wrap is registered: wrap <= tc on every edge. It is therefore high for exactly the one cycle after a wrap edge.
- A load never produces tc or wrap, including a load whose value is 0 or MAX.
- Out-of-range state (q > MAX) is unreachable from reset or load.
- All arithmetic is WIDTH bits wide, and the modulo is taken at MAX, not at 2**WIDTH. There is no carry out beyond tc.
- Direction may change on any cycle; the new direction takes effect at the next edge with no dead cycle.

## Timing
- Count latency is 1 cycle: en sampled at edge k gives the updated q after edge k.
- Load latency is 1 cycle.
- t, tc and qb are valid combinationally within the same cycle as their inputs. There is no registered path from en, up, load or d to t or tc.
- wrap lags tc by exactly 1 cycle.
- Asserting rst at any time, including mid-count or in a tc cycle, forces q=0 and wrap=0 immediately, without waiting for clk.
- Deassertion of rst is synchronous to clk. The first edge after release applies the normal next-state rules from q=0.
- Simultaneous load and en: load wins and tc=0.
- With en held high and up held constant, q cycles with period MAX+1.

## Test plan
- Reset: rst=1 mid-count at q=7, asserted between clock edges -> q=0, qb=4'hF, wrap=0 immediately; after release with en=1, up=1 -> q=1.
- Decade up (WIDTH=4, MAX=9): en=1, up=1 from 0 for 12 cycles -> q=0..9,0,1,2; tc high only while q=9; wrap high the cycle q=0 after the wrap; t=4'b1001 at q=9.
- Decade down: load d=0, then en=1, up=0 -> q=9,8,...; tc high while q=0 and en=1; t at q=0 equals 4'b1001.
- Load clip and priority: load=1, en=1, d=13 with MAX=9 -> q=9, tc=0, wrap=0 on the next cycle.
- T-cell shadow: drive 4 reference T flip-flops (shared clk/rst) with t under random en/up/load for 1000 cycles -> shadow state == q every cycle.
- Hold and direction flip: en=0 at q=5 -> q stays 5, t=0, tc=0; en=1 with up toggling each cycle from q=5 -> q=6,5,6,5.
